dram_cmd_frontend: RTL and testbench
====================================

DRAM_CMD_FRONTEND -- requirements
Module: dram_cmd_frontend

Interface
REQ-001 Parameter DATA_W, default 8: width of the write data and the read data.
REQ-002 Parameter ADDR_W, default 15: width of the command address.
REQ-003 Parameter DEPTH, default 4: command queue entries; power of 2, at least 2.
REQ-004 Parameter DEBOUNCE_CYC, default 4: stable-sample count used when debounce is compiled in; at least 1.
REQ-005 Port sysclk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port RESET_SM, input, 1: asynchronous active-high reset.
REQ-007 Port btnl, input, 1: asynchronous write button.
REQ-008 Port btnr, input, 1: asynchronous read button.
REQ-009 Port switch, input, DATA_W: write data, sampled at push.
REQ-010 Port req_addr, input, ADDR_W: command address, sampled at push.
REQ-011 Port cmd_valid, output, 1: queue head valid.
REQ-012 Port cmd_ready, input, 1: controller accepts the head.
REQ-013 Port cmd_we, output, 1: head type, 1 = write, 0 = read.
REQ-014 Port cmd_addr, output, ADDR_W: head address.
REQ-015 Port cmd_wdata, output, DATA_W: head data.
REQ-016 Port rd_valid, input, 1: one-cycle read-return strobe.
REQ-017 Port rd_data, input, DATA_W: read-return data.
REQ-018 Port led, output, DATA_W: last returned read data.
REQ-019 Port full, output, 1: queue full flag.
REQ-020 Port ovf, output, 1: sticky drop flag.
REQ-021 Port rd_err, output, 1: sticky flag for an unexpected read return.

Function
REQ-022 btnl and btnr SHALL each pass through a 2-flop synchronizer; a push request is the synchronized rising edge (sync2=1 while prev=0).
REQ-023 Without debounce, cmd_valid SHALL rise 3 sysclk edges after the first edge that samples the button high, given an empty queue.
REQ-024 A btnl edge SHALL push {we=1, req_addr, switch}; a btnr edge SHALL push {we=0, req_addr, 0}.
REQ-025 If btnl and btnr edges occur in the same cycle, the write SHALL be pushed, the read dropped, and ovf set.
REQ-026 cmd_valid SHALL equal not-empty; cmd_we, cmd_addr and cmd_wdata SHALL present the head entry while cmd_valid=1 and hold it stable until the pop.
REQ-027 A pop SHALL occur on each edge where cmd_valid and cmd_ready are both 1; cmd_ready while the queue is empty SHALL have no effect.
REQ-028 A push while full SHALL be discarded and set ovf, unless a pop occurs in the same cycle, in which case the push SHALL be accepted and the count stays at DEPTH.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH, with full = (count==DEPTH).
REQ-030 An outstanding-read counter (0..DEPTH) SHALL increment when a read pops and decrement on rd_valid; if both occur in the same cycle it SHALL stay unchanged.
REQ-031 On rd_valid with an outstanding count of 0 (and no same-cycle read pop), rd_data SHALL be ignored and rd_err set; otherwise led SHALL load rd_data on that edge.
REQ-032 ovf and rd_err SHALL clear only on reset.

Reset
REQ-033 RESET_SM=1 SHALL immediately clear pointers, count and the outstanding counter, and force cmd_valid=0, cmd_we=0, cmd_addr=0, cmd_wdata=0, led=0, full=0, ovf=0 and rd_err=0.
REQ-034 Reset SHALL set the synchronizer and edge-history flops to 0.
REQ-035 A button held high through reset release SHALL produce exactly one push after release.
REQ-036 A reset asserted mid-handshake SHALL drop all queued and outstanding commands.

Configuration
REQ-037 With DRAM_FE_DEBOUNCE_EN defined, each synchronized button SHALL be accepted only after DEBOUNCE_CYC consecutive equal samples, adding DEBOUNCE_CYC cycles to the REQ-023 latency.
REQ-038 Without DRAM_FE_DEBOUNCE_EN, the synchronized button SHALL feed edge detection directly and no debounce counters SHALL exist.

Verification
REQ-039 Without debounce: btnl pulsed 1 cycle, switch=8'hAA, req_addr=5 -> cmd_valid high 3 edges later with cmd_we=1, cmd_addr=5, cmd_wdata=8'hAA; cmd_ready=1 -> cmd_valid=0 next cycle.
REQ-040 cmd_ready=0 and 5 btnl edges with DEPTH=4 -> full=1 after the 4th push, ovf=1 after the 5th; drained order matches push order.
REQ-041 btnr edge, then pop, then rd_valid with rd_data=8'h0F -> led=8'h0F and rd_err=0; a second rd_valid -> rd_err=1 with led still 8'h0F.
REQ-042 btnl and btnr rising in the same cycle -> exactly one write entry queued and ovf=1.
REQ-043 Queue full with cmd_ready=1 and a btnl edge in the same cycle -> count stays 4 and ovf stays 0.
REQ-044 With DRAM_FE_DEBOUNCE_EN, a btnl glitch shorter than DEBOUNCE_CYC cycles -> no push; RESET_SM asserted with 2 entries queued -> cmd_valid=0 immediately.

Source files
------------

// File: rtl/dram_cmd_frontend.sv
// Button-driven DRAM command front end: synchronizes the two push buttons, detects
// rising edges, queues write/read commands and tracks read returns.
// Latency: button high sampled -> cmd_valid after 3 sysclk edges (+DEBOUNCE_CYC with debounce).
// Backpressure: queue holds DEPTH commands; a push into a full queue with no pop is dropped (ovf).
//
// Optional feature macro: DRAM_FE_DEBOUNCE_EN -- adds a DEBOUNCE_CYC-sample stability
// filter between each button synchronizer and its edge detector.
//
// Ports:
//   sysclk, RESET_SM            clock, asynchronous active-high reset
//   btnl, btnr                  asynchronous write / read push buttons
//   switch, req_addr            write data and address captured at push
//   cmd_valid/cmd_ready         head-of-queue handshake toward the DRAM controller
//   cmd_we, cmd_addr, cmd_wdata head entry (all zero while the queue is empty)
//   rd_valid, rd_data           read-return strobe and data
//   led                         last accepted read data
//   full, ovf, rd_err           queue full, sticky drop, sticky unexpected read return

`ifdef DRAM_FE_DEBOUNCE_EN
// Stability filter for one synchronized button.
// Latency: output follows a new input level after CYC consecutive equal samples.
// Backpressure: none.
module dram_fe_debounce #(
  parameter int CYC = 4
) (
  input  logic sysclk,
  input  logic RESET_SM,
  input  logic din,
  output logic dout
);
  localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;

  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that differ from the current output; any
  // sample agreeing with the output restarts the run.
  always_ff @(posedge sysclk or posedge RESET_SM) begin
    if (RESET_SM) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(CYC - 1)) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule
`endif

module dram_cmd_frontend #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 15,
  parameter int DEPTH        = 4,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              sysclk,
  input  logic              RESET_SM,
  input  logic              btnl,
  input  logic              btnr,
  input  logic [DATA_W-1:0] switch,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] led,
  output logic              full,
  output logic              ovf,
  output logic              rd_err
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Elaboration-time guard against unsupported configurations.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEBOUNCE_CYC < 1) begin : g_bad_param
    $error("dram_cmd_frontend: DEPTH must be a power of 2 >= 2 and DEBOUNCE_CYC >= 1");
  end

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Button synchronizers ([1] is the second, metastability-safe stage)
  // ---------------------------------------------------------------------------
  logic [1:0] l_sync, r_sync;

  always_ff @(posedge sysclk or posedge RESET_SM) begin
    if (RESET_SM) begin
      l_sync <= 2'b00;
      r_sync <= 2'b00;
    end else begin
      l_sync <= {l_sync[0], btnl};
      r_sync <= {r_sync[0], btnr};
    end
  end

  logic l_clean, r_clean;

`ifdef DRAM_FE_DEBOUNCE_EN
  dram_fe_debounce #(.CYC(DEBOUNCE_CYC)) u_db_l (
    .sysclk   (sysclk),
    .RESET_SM (RESET_SM),
    .din      (l_sync[1]),
    .dout     (l_clean)
  );
  dram_fe_debounce #(.CYC(DEBOUNCE_CYC)) u_db_r (
    .sysclk   (sysclk),
    .RESET_SM (RESET_SM),
    .din      (r_sync[1]),
    .dout     (r_clean)
  );
`else
  assign l_clean = l_sync[1];
  assign r_clean = r_sync[1];
`endif

  // ---------------------------------------------------------------------------
  // Rising-edge detection. History resets to 0, so a button held through reset
  // release yields exactly one edge once its synchronized level reaches 1.
  // ---------------------------------------------------------------------------
  logic l_prev, r_prev;
  logic l_edge, r_edge;

  always_ff @(posedge sysclk or posedge RESET_SM) begin
    if (RESET_SM) begin
      l_prev <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      l_prev <= l_clean;
      r_prev <= r_clean;
    end
  end

  assign l_edge = l_clean & ~l_prev;
  assign r_edge = r_clean & ~r_prev;

  // ---------------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------------
  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  cmd_t             head;
  cmd_t             push_ent;
  logic             push_req, push_ok, pop, drop;

  assign head      = mem[rd_ptr];
  assign cmd_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = cmd_valid & cmd_ready;

  // Write wins a same-cycle collision; the read is then dropped.
  always_comb begin
    push_ent = '0;
    if (l_edge) begin
      push_ent.we    = 1'b1;
      push_ent.addr  = req_addr;
      push_ent.wdata = switch;
    end else if (r_edge) begin
      push_ent.we    = 1'b0;
      push_ent.addr  = req_addr;
      push_ent.wdata = '0;
    end
  end

  assign push_req = l_edge | r_edge;
  // A same-cycle pop frees the slot, so a push into a full queue is still taken.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = (l_edge & r_edge) | (push_req & full & ~pop);

  // Storage needs no reset: every read of it is qualified by count.
  always_ff @(posedge sysclk) begin
    if (push_ok) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge sysclk or posedge RESET_SM) begin
    if (RESET_SM) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head fields are forced to zero while the queue is empty.
  assign cmd_we    = cmd_valid & head.we;
  assign cmd_addr  = cmd_valid ? head.addr  : '0;
  assign cmd_wdata = cmd_valid ? head.wdata : '0;

  // ---------------------------------------------------------------------------
  // Read-return tracking
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] rd_out;
  logic             rd_pop, rd_accept;

  assign rd_pop    = pop & ~head.we;
  // A return in the same cycle as its read's pop is treated as expected.
  assign rd_accept = rd_valid & ((rd_out != '0) | rd_pop);

  always_ff @(posedge sysclk or posedge RESET_SM) begin
    if (RESET_SM) begin
      rd_out <= '0;
      led    <= '0;
      ovf    <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      case ({rd_pop, rd_valid})
        2'b10:   if (rd_out != CNT_W'(DEPTH)) rd_out <= rd_out + CNT_W'(1);
        2'b01:   if (rd_out != '0)            rd_out <= rd_out - CNT_W'(1);
        default: rd_out <= rd_out;
      endcase
      if (rd_accept)            led    <= rd_data;
      if (rd_valid & ~rd_accept) rd_err <= 1'b1;
      if (drop)                 ovf    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dram_cmd_frontend.sv
// Self-checking bench for dram_cmd_frontend: scoreboard of expected queue entries,
// one task per scenario, inputs driven and outputs sampled on the falling edge.
// Works with or without DRAM_FE_DEBOUNCE_EN (timing scales with the debounce length).
module tb_dram_cmd_frontend;
  localparam int DBC = 4;
`ifdef DRAM_FE_DEBOUNCE_EN
  localparam int DB = DBC;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = 3 + DB;   // edges from first high sample to cmd_valid
  localparam int PW  = DB + 1;   // button press width in cycles
  localparam int GAP = DB + 4;   // low time after a press

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        sysclk = 1'b0;
  logic        RESET_SM, btnl, btnr, cmd_ready, rd_valid;
  logic [7:0]  switch, rd_data;
  logic [14:0] req_addr;
  logic        cmd_valid, cmd_we, full, ovf, rd_err;
  logic [14:0] cmd_addr;
  logic [7:0]  cmd_wdata, led;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   check_cnt = 0;

  always #5 sysclk = ~sysclk;

  dram_cmd_frontend #(.DATA_W(8), .ADDR_W(15), .DEPTH(4), .DEBOUNCE_CYC(DBC)) dut (
    .sysclk(sysclk), .RESET_SM(RESET_SM), .btnl(btnl), .btnr(btnr),
    .switch(switch), .req_addr(req_addr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rd_valid(rd_valid),
    .rd_data(rd_data), .led(led), .full(full), .ovf(ovf), .rd_err(rd_err)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic apply_reset();
    RESET_SM = 1'b1; btnl = 1'b0; btnr = 1'b0; cmd_ready = 1'b0; rd_valid = 1'b0;
    rd_data = '0; switch = '0; req_addr = '0;
    tick(2);
    RESET_SM = 1'b0;
    tick(1);
    exp_q.delete();
  endtask

  task automatic press(input logic l, input logic r, input logic [14:0] a, input logic [7:0] d);
    req_addr = a; switch = d; btnl = l; btnr = r;
    tick(PW);
    btnl = 1'b0; btnr = 1'b0;
    tick(GAP);
  endtask

  task automatic test_reset();
    exp_t e, got;
    RESET_SM = 1'b1; btnl = 1'b1; btnr = 1'b0; cmd_ready = 1'b0; rd_valid = 1'b0;
    rd_data = '0; switch = 8'h3C; req_addr = 15'h0123;
    tick(3);
    check_cnt++; if (cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid: got %b expected 0", cmd_valid); else pass_cnt++;
    check_cnt++; if (cmd_we !== 1'b0) $display("FAIL rst_cmd_we: got %b expected 0", cmd_we); else pass_cnt++;
    check_cnt++; if (cmd_addr !== 15'h0) $display("FAIL rst_cmd_addr: got %h expected 0", cmd_addr); else pass_cnt++;
    check_cnt++; if (cmd_wdata !== 8'h00) $display("FAIL rst_cmd_wdata: got %h expected 0", cmd_wdata); else pass_cnt++;
    check_cnt++; if (led !== 8'h00) $display("FAIL rst_led: got %h expected 0", led); else pass_cnt++;
    check_cnt++; if ({full, ovf, rd_err} !== 3'b000) $display("FAIL rst_flags: got %b expected 000", {full, ovf, rd_err}); else pass_cnt++;
    // Button held through release: exactly one push.
    RESET_SM = 1'b0;
    exp_q.delete();
    exp_q.push_back('{we: 1'b1, addr: 15'h0123, data: 8'h3C});
    tick(LAT + 3);
    got = {cmd_we, cmd_addr, cmd_wdata};
    e = exp_q.pop_front();
    check_cnt++; if (cmd_valid !== 1'b1 || got !== e) $display("FAIL held_btn_push: got v=%b %h expected v=1 %h", cmd_valid, got, e); else pass_cnt++;
    cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;
    tick(3);
    check_cnt++; if (cmd_valid !== 1'b0) $display("FAIL held_btn_once: got cmd_valid=%b expected 0", cmd_valid); else pass_cnt++;
    btnl = 1'b0;
    tick(GAP);
  endtask

  task automatic test_single_write();
    exp_t e, got;
    apply_reset();
    req_addr = 15'd5; switch = 8'hAA; btnl = 1'b1;
    exp_q.push_back('{we: 1'b1, addr: 15'd5, data: 8'hAA});
    for (int i = 1; i <= LAT; i++) begin
      tick(1);
      if (i == PW) btnl = 1'b0;
      if (i == LAT - 1) begin
        check_cnt++; if (cmd_valid !== 1'b0) $display("FAIL wr_early: got cmd_valid=%b expected 0 at edge %0d", cmd_valid, i); else pass_cnt++;
      end
    end
    got = {cmd_we, cmd_addr, cmd_wdata};
    e = exp_q.pop_front();
    check_cnt++; if (cmd_valid !== 1'b1 || got !== e) $display("FAIL wr_latency: got v=%b %h expected v=1 %h", cmd_valid, got, e); else pass_cnt++;
    cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;
    check_cnt++; if (cmd_valid !== 1'b0) $display("FAIL wr_pop: got cmd_valid=%b expected 0", cmd_valid); else pass_cnt++;
  endtask

  task automatic test_fill_ovf();
    exp_t e, got;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0, 15'(16 + i), 8'(8'h10 + i));
      if (exp_q.size() < 4) exp_q.push_back('{we: 1'b1, addr: 15'(16 + i), data: 8'(8'h10 + i)});
      if (i == 3) begin
        check_cnt++; if ({full, ovf} !== 2'b10) $display("FAIL fill_4: got full,ovf=%b expected 10", {full, ovf}); else pass_cnt++;
      end
    end
    check_cnt++; if ({full, ovf} !== 2'b11) $display("FAIL fill_5_ovf: got full,ovf=%b expected 11", {full, ovf}); else pass_cnt++;
    cmd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (cmd_valid) begin
        got = {cmd_we, cmd_addr, cmd_wdata};
        if (exp_q.size() == 0) begin
          check_cnt++; $display("FAIL fill_extra: got %h expected no entry", got);
        end else begin
          e = exp_q.pop_front();
          check_cnt++; if (got !== e) $display("FAIL fill_order: got %h expected %h", got, e); else pass_cnt++;
        end
      end
      tick(1);
    end
    cmd_ready = 1'b0;
    check_cnt++; if (exp_q.size() != 0) $display("FAIL fill_missing: got %0d undrained expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_read_return();
    exp_t e, got;
    apply_reset();
    press(1'b0, 1'b1, 15'd7, 8'hFF);
    exp_q.push_back('{we: 1'b0, addr: 15'd7, data: 8'h00});
    got = {cmd_we, cmd_addr, cmd_wdata};
    e = exp_q.pop_front();
    check_cnt++; if (cmd_valid !== 1'b1 || got !== e) $display("FAIL rd_entry: got v=%b %h expected v=1 %h", cmd_valid, got, e); else pass_cnt++;
    cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;
    rd_data = 8'h0F; rd_valid = 1'b1; tick(1); rd_valid = 1'b0;
    check_cnt++; if (led !== 8'h0F || rd_err !== 1'b0) $display("FAIL rd_return: got led=%h err=%b expected 0f 0", led, rd_err); else pass_cnt++;
    rd_data = 8'h55; rd_valid = 1'b1; tick(1); rd_valid = 1'b0;
    check_cnt++; if (led !== 8'h0F || rd_err !== 1'b1) $display("FAIL rd_unexpected: got led=%h err=%b expected 0f 1", led, rd_err); else pass_cnt++;
  endtask

  task automatic test_read_same_cycle();
    apply_reset();
    press(1'b0, 1'b1, 15'd9, 8'h00);
    cmd_ready = 1'b1; rd_valid = 1'b1; rd_data = 8'hC3;
    tick(1);
    cmd_ready = 1'b0; rd_valid = 1'b0;
    check_cnt++; if (led !== 8'hC3 || rd_err !== 1'b0) $display("FAIL rd_same_cycle: got led=%h err=%b expected c3 0", led, rd_err); else pass_cnt++;
    rd_data = 8'h11; rd_valid = 1'b1; tick(1); rd_valid = 1'b0;
    check_cnt++; if (led !== 8'hC3 || rd_err !== 1'b1) $display("FAIL rd_same_cycle_cnt: got led=%h err=%b expected c3 1", led, rd_err); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    exp_t e, got;
    apply_reset();
    press(1'b1, 1'b1, 15'h21, 8'h5A);
    exp_q.push_back('{we: 1'b1, addr: 15'h21, data: 8'h5A});
    check_cnt++; if (ovf !== 1'b1) $display("FAIL simul_ovf: got %b expected 1", ovf); else pass_cnt++;
    cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (cmd_valid) begin
        got = {cmd_we, cmd_addr, cmd_wdata};
        if (exp_q.size() == 0) begin
          check_cnt++; $display("FAIL simul_extra: got %h expected no entry", got);
        end else begin
          e = exp_q.pop_front();
          check_cnt++; if (got !== e) $display("FAIL simul_entry: got %h expected %h", got, e); else pass_cnt++;
        end
      end
      tick(1);
    end
    cmd_ready = 1'b0;
    check_cnt++; if (exp_q.size() != 0) $display("FAIL simul_missing: got %0d undrained expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_full_pop_push();
    exp_t e, got;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, 15'(32 + i), 8'(8'hA0 + i));
      exp_q.push_back('{we: 1'b1, addr: 15'(32 + i), data: 8'(8'hA0 + i)});
    end
    check_cnt++; if (full !== 1'b1) $display("FAIL fpp_full: got %b expected 1", full); else pass_cnt++;
    req_addr = 15'h40; switch = 8'h99; btnl = 1'b1;
    exp_q.push_back('{we: 1'b1, addr: 15'h40, data: 8'h99});
    for (int i = 1; i < LAT; i++) begin
      tick(1);
      if (i == PW) btnl = 1'b0;
    end
    // Next edge carries both the push and this pop.
    got = {cmd_we, cmd_addr, cmd_wdata};
    e = exp_q.pop_front();
    check_cnt++; if (got !== e) $display("FAIL fpp_head: got %h expected %h", got, e); else pass_cnt++;
    cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0; btnl = 1'b0;
    check_cnt++; if ({full, ovf} !== 2'b10) $display("FAIL fpp_count: got full,ovf=%b expected 10", {full, ovf}); else pass_cnt++;
    tick(GAP);
    cmd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (cmd_valid) begin
        got = {cmd_we, cmd_addr, cmd_wdata};
        if (exp_q.size() == 0) begin
          check_cnt++; $display("FAIL fpp_extra: got %h expected no entry", got);
        end else begin
          e = exp_q.pop_front();
          check_cnt++; if (got !== e) $display("FAIL fpp_order: got %h expected %h", got, e); else pass_cnt++;
        end
      end
      tick(1);
    end
    cmd_ready = 1'b0;
    check_cnt++; if (exp_q.size() != 0) $display("FAIL fpp_missing: got %0d undrained expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    press(1'b0, 1'b1, 15'h11, 8'h00);
    press(1'b1, 1'b0, 15'h12, 8'h22);
    press(1'b1, 1'b0, 15'h13, 8'h33);
    cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;   // read popped, now outstanding
    check_cnt++; if (cmd_valid !== 1'b1) $display("FAIL mid_pre: got cmd_valid=%b expected 1", cmd_valid); else pass_cnt++;
    #2 RESET_SM = 1'b1;
    #1;
    check_cnt++; if (cmd_valid !== 1'b0 || cmd_addr !== 15'h0) $display("FAIL mid_async: got v=%b addr=%h expected 0 0", cmd_valid, cmd_addr); else pass_cnt++;
    tick(1);
    RESET_SM = 1'b0;
    exp_q.delete();
    tick(2);
    rd_data = 8'h77; rd_valid = 1'b1; tick(1); rd_valid = 1'b0;
    check_cnt++; if (rd_err !== 1'b1 || led !== 8'h00 || cmd_valid !== 1'b0) $display("FAIL mid_dropped: got err=%b led=%h v=%b expected 1 00 0", rd_err, led, cmd_valid); else pass_cnt++;
  endtask

`ifdef DRAM_FE_DEBOUNCE_EN
  task automatic test_debounce_glitch();
    apply_reset();
    req_addr = 15'h3; switch = 8'h44; btnl = 1'b1;
    tick(DB - 1);
    btnl = 1'b0;
    tick(DB + 8);
    check_cnt++; if (cmd_valid !== 1'b0) $display("FAIL db_glitch: got cmd_valid=%b expected 0", cmd_valid); else pass_cnt++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    RESET_SM = 1'b1; btnl = 1'b0; btnr = 1'b0; cmd_ready = 1'b0; rd_valid = 1'b0;
    rd_data = '0; switch = '0; req_addr = '0;
    test_reset();
    test_single_write();
    test_fill_ovf();
    test_read_return();
    test_read_same_cycle();
    test_simultaneous();
    test_full_pop_push();
    test_reset_mid();
`ifdef DRAM_FE_DEBOUNCE_EN
    test_debounce_glitch();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
